mc14500_wide: RTL and testbench
===============================

MC14500_WIDE -- requirements
Module: mc14500_wide

Interface
REQ-001 SHALL have parameter WIDTH, default 1: bit width of result register and data path.
REQ-002 SHALL have parameter AW, default 8: program-counter and address width.
REQ-003 SHALL have parameter DEPTH, default 4: return-stack entries (power of two, >=2).
REQ-004 SHALL have ports: X2 in 1 clock; RST in 1 reset; one clock, reset synchronous active-high.
REQ-005 SHALL have ports: EN in 1 execute enable; I in 4 opcode; ADDR_IN in AW jump target; DATA_IN in WIDTH input data.
REQ-006 SHALL have ports: PC out AW program address; RR out WIDTH result register; DATA_OUT out WIDTH store data; WRITE out 1 store strobe.
REQ-007 SHALL have ports: JMP out 1, RTN out 1, FLAG_O out 1, FLAG_F out 1 decode pulses; STK_ERR out 1 sticky stack fault.

Function
REQ-008 SHALL execute one instruction per X2 rising edge when EN=1; EN=0 holds all state and forces WRITE/JMP/RTN/FLAG_O/FLAG_F low.
REQ-009 SHALL decode I: 0 NOPO, 1 LD, 2 LDC, 3 AND, 4 ANDC, 5 OR, 6 ORC, 7 XNOR, 8 STO, 9 STOC, A IEN, B OEN, C JMP, D RTN, E SKZ, F NOPF.
REQ-010 SHALL gate data as D = DATA_IN & {WIDTH{IEN}}.
REQ-011 SHALL update RR bitwise: LD RR<=D; LDC RR<=~D; AND RR&D; ANDC RR&~D; OR RR|D; ORC RR|~D; XNOR ~(RR^D); other opcodes hold RR.
REQ-012 SHALL latch IEN<=DATA_IN[0] on IEN and OEN<=DATA_IN[0] on OEN.
REQ-013 SHALL drive WRITE combinationally = EN & ~skip & OEN & (I==STO|I==STOC).
REQ-014 SHALL drive DATA_OUT = RR for STO, ~RR for STOC, all-zero when WRITE=0.
REQ-015 SHALL drive FLAG_O/FLAG_F/JMP/RTN combinationally high for NOPO/NOPF/JMP/RTN when EN=1 and skip=0.
REQ-016 SHALL increment PC by 1 (modulo 2^AW, wrapping) for every enabled cycle not redirected.
REQ-017 SHALL, on JMP: push PC+1 to stack, PC<=ADDR_IN.
REQ-018 SHALL, on JMP with stack full: discard push, set STK_ERR, still load PC<=ADDR_IN.
REQ-019 SHALL, on RTN: pop, PC<=popped value, set skip for next instruction.
REQ-020 SHALL, on RTN with stack empty: set STK_ERR, PC<=PC+1, still set skip.
REQ-021 SHALL, on SKZ: set skip when RR is all-zero.
REQ-022 SHALL treat a skipped instruction as a no-op: no RR/IEN/OEN/stack change, no output pulses, PC+1, skip cleared.
REQ-023 SHALL hold skip across EN=0 cycles, consuming it only on the next enabled cycle.
REQ-024 SHALL keep STK_ERR set until RST.

Reset
REQ-025 SHALL on RST=1 at X2 edge set PC=0, RR=0, IEN=1, OEN=1, skip=0, stack pointer=0, STK_ERR=0; RST overrides EN.
REQ-026 SHALL, while RST=1, force WRITE, JMP, RTN, FLAG_O, FLAG_F low and DATA_OUT zero.
REQ-027 SHALL abandon any in-progress skip or stack content on reset mid-program.

Structure
REQ-028 SHALL place opcode constants 0x0-0xF in shared package mc14500_pkg.
REQ-029 SHALL implement return stack as sub-module mc14500_stack (push, pop, full, empty, DEPTH x AW storage, synchronous RST).

Verification
REQ-030 SHALL test WIDTH=4: IEN DATA_IN=1; LD 0xA; AND 0x6 -> RR=0x2; XNOR 0x2 -> RR=0xF.
REQ-031 SHALL test OEN=1, RR=0x5, STOC -> WRITE=1, DATA_OUT=0xA; OEN DATA_IN=0 then STO -> WRITE=0, DATA_OUT=0.
REQ-032 SHALL test PC=0x10, JMP ADDR_IN=0x40 -> PC=0x40, JMP=1; later RTN -> PC=0x11, next instruction skipped (RR unchanged).
REQ-033 SHALL test DEPTH=4: five nested JMPs -> STK_ERR=1 after fifth; RTN on empty stack after reset -> STK_ERR=1, PC increments.
REQ-034 SHALL test RR=0, SKZ, EN=0 two cycles, then LD -> LD skipped, PC advances by 2 total from SKZ.
REQ-035 SHALL test PC=0xFF (AW=8) NOPO -> PC=0x00, FLAG_O=1; RST mid-subroutine -> PC=0, STK_ERR=0, IEN=OEN=1.

Source files
------------

// File: rtl/mc14500_pkg.sv
// Shared opcode encoding for the widened MC14500 one-bit-style controller.
package mc14500_pkg;

  typedef enum logic [3:0] {
    OP_NOPO = 4'h0,
    OP_LD   = 4'h1,
    OP_LDC  = 4'h2,
    OP_AND  = 4'h3,
    OP_ANDC = 4'h4,
    OP_OR   = 4'h5,
    OP_ORC  = 4'h6,
    OP_XNOR = 4'h7,
    OP_STO  = 4'h8,
    OP_STOC = 4'h9,
    OP_IEN  = 4'hA,
    OP_OEN  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RTN  = 4'hD,
    OP_SKZ  = 4'hE,
    OP_NOPF = 4'hF
  } op_e;

endpackage

// File: rtl/mc14500_stack.sv
// Return-address stack: DEPTH entries of AW bits, full/empty flags, synchronous reset.
module mc14500_stack #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int PW  = $clog2(DEPTH);
  localparam int SPW = PW + 1;

  logic [SPW-1:0] sp_q, sp_d;
  logic [AW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  mem_d [DEPTH];
  logic [PW-1:0]  wr_idx_s, top_idx_s;

  // Pointer arithmetic, flags and the read port of the top entry.
  always_comb begin
    wr_idx_s  = sp_q[PW-1:0];
    top_idx_s = sp_q[PW-1:0] - PW'(1);
    full      = (sp_q == SPW'(DEPTH));
    empty     = (sp_q == {SPW{1'b0}});
    pop_data  = mem_q[top_idx_s];
  end

  // Next pointer and storage; callers never push when full or pop when empty.
  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (push && !full) begin
      sp_d            = sp_q + SPW'(1);
      mem_d[wr_idx_s] = push_data;
    end else if (pop && !empty) begin
      sp_d = sp_q - SPW'(1);
    end else begin
      sp_d = sp_q;
    end
  end

  // Stack registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= {SPW{1'b0}};
      mem_q <= '{default: {AW{1'b0}}};
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/mc14500_wide.sv
// MC14500-style industrial control unit with a WIDTH-bit result register,
// program counter, skip logic and a small return stack for JMP/RTN.
module mc14500_wide
  import mc14500_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic             X2,
  input  logic             RST,
  input  logic             EN,
  input  logic [3:0]       I,
  input  logic [AW-1:0]    ADDR_IN,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic [AW-1:0]    PC,
  output logic [WIDTH-1:0] RR,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             WRITE,
  output logic             JMP,
  output logic             RTN,
  output logic             FLAG_O,
  output logic             FLAG_F,
  output logic             STK_ERR
);

  logic [AW-1:0]    pc_q, pc_d, pc_inc_s, pop_data_s;
  logic [WIDTH-1:0] rr_q, rr_d, d_s;
  logic             ien_q, ien_d, oen_q, oen_d, skip_q, skip_d, stk_err_q, stk_err_d;
  logic             push_s, pop_s, full_s, empty_s, exec_s;
  op_e              op_s;

  mc14500_stack #(.DEPTH(DEPTH), .AW(AW)) u_stack (
    .clk       (X2),
    .rst       (RST),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_inc_s),
    .pop_data  (pop_data_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Decode pulses and store port; reset and a pending skip silence them.
  always_comb begin
    op_s     = op_e'(I);
    exec_s   = EN & ~RST & ~skip_q;
    d_s      = DATA_IN & {WIDTH{ien_q}};
    pc_inc_s = pc_q + AW'(1);
    WRITE    = exec_s & oen_q & ((op_s == OP_STO) | (op_s == OP_STOC));
    JMP      = exec_s & (op_s == OP_JMP);
    RTN      = exec_s & (op_s == OP_RTN);
    FLAG_O   = exec_s & (op_s == OP_NOPO);
    FLAG_F   = exec_s & (op_s == OP_NOPF);
    if (WRITE) begin
      DATA_OUT = (op_s == OP_STOC) ? ~rr_q : rr_q;
    end else begin
      DATA_OUT = {WIDTH{1'b0}};
    end
    PC      = pc_q;
    RR      = rr_q;
    STK_ERR = stk_err_q;
  end

  // Instruction execution: next-state for PC, RR, enables, skip and fault flag.
  always_comb begin
    pc_d      = pc_q;
    rr_d      = rr_q;
    ien_d     = ien_q;
    oen_d     = oen_q;
    skip_d    = skip_q;
    stk_err_d = stk_err_q;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    if (EN) begin
      pc_d   = pc_inc_s;
      skip_d = 1'b0;
      if (!skip_q) begin
        case (op_s)
          OP_LD:   rr_d = d_s;
          OP_LDC:  rr_d = ~d_s;
          OP_AND:  rr_d = rr_q & d_s;
          OP_ANDC: rr_d = rr_q & ~d_s;
          OP_OR:   rr_d = rr_q | d_s;
          OP_ORC:  rr_d = rr_q | ~d_s;
          OP_XNOR: rr_d = ~(rr_q ^ d_s);
          OP_IEN:  ien_d = DATA_IN[0];
          OP_OEN:  oen_d = DATA_IN[0];
          OP_JMP: begin
            // A full stack loses the return address but the jump still happens.
            pc_d = ADDR_IN;
            if (full_s) begin
              stk_err_d = 1'b1;
            end else begin
              push_s = 1'b1;
            end
          end
          OP_RTN: begin
            skip_d = 1'b1;
            if (empty_s) begin
              stk_err_d = 1'b1;
            end else begin
              pop_s = 1'b1;
              pc_d  = pop_data_s;
            end
          end
          OP_SKZ:  skip_d = (rr_q == {WIDTH{1'b0}});
          default: rr_d = rr_q;
        endcase
      end else begin
        rr_d = rr_q;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // Architectural state registers.
  always_ff @(posedge X2) begin
    if (RST) begin
      pc_q      <= {AW{1'b0}};
      rr_q      <= {WIDTH{1'b0}};
      ien_q     <= 1'b1;
      oen_q     <= 1'b1;
      skip_q    <= 1'b0;
      stk_err_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      rr_q      <= rr_d;
      ien_q     <= ien_d;
      oen_q     <= oen_d;
      skip_q    <= skip_d;
      stk_err_q <= stk_err_d;
    end
  end

endmodule

// File: tb/tb_mc14500_wide.sv
// Directed self-checking bench for mc14500_wide at WIDTH=4, AW=8, DEPTH=4.
module tb_mc14500_wide;
  import mc14500_pkg::*;

  logic       X2 = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic [3:0] I = 4'h0;
  logic [7:0] ADDR_IN = 8'h00;
  logic [3:0] DATA_IN = 4'h0;
  logic [7:0] PC;
  logic [3:0] RR, DATA_OUT;
  logic       WRITE, JMP, RTN, FLAG_O, FLAG_F, STK_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  mc14500_wide #(.WIDTH(4), .AW(8), .DEPTH(4)) dut (
    .X2(X2), .RST(RST), .EN(EN), .I(I), .ADDR_IN(ADDR_IN), .DATA_IN(DATA_IN),
    .PC(PC), .RR(RR), .DATA_OUT(DATA_OUT), .WRITE(WRITE), .JMP(JMP), .RTN(RTN),
    .FLAG_O(FLAG_O), .FLAG_F(FLAG_F), .STK_ERR(STK_ERR)
  );

  always #5 X2 = ~X2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic en, input logic [3:0] op, input logic [3:0] din,
                        input logic [7:0] adr);
    EN = en; I = op; DATA_IN = din; ADDR_IN = adr;
    #1;
  endtask

  task automatic tick;
    @(posedge X2);
    #1;
  endtask

  task automatic run(input logic [3:0] op, input logic [3:0] din, input logic [7:0] adr);
    set_in(1'b1, op, din, adr);
    tick();
  endtask

  initial begin
    // Reset forces pulses low even with EN=1
    set_in(1'b1, OP_STO, 4'h3, 8'h00);
    check_eq("rst_write", WRITE, 0);
    check_eq("rst_dout", DATA_OUT, 0);
    set_in(1'b1, OP_NOPO, 4'h0, 8'h00);
    check_eq("rst_flag_o", FLAG_O, 0);
    tick(); tick();
    check_eq("rst_pc", PC, 0);
    check_eq("rst_rr", RR, 0);
    check_eq("rst_stk_err", STK_ERR, 0);
    RST = 1'b0;

    // Logic ops
    run(OP_IEN, 4'h1, 8'h00);
    run(OP_LD, 4'hA, 8'h00);
    check_eq("ld_a", RR, 4'hA);
    run(OP_AND, 4'h6, 8'h00);
    check_eq("and_6", RR, 4'h2);
    run(OP_XNOR, 4'h2, 8'h00);
    check_eq("xnor_2", RR, 4'hF);
    check_eq("pc_after_alu", PC, 8'h04);
    run(OP_IEN, 4'h0, 8'h00);
    run(OP_LD, 4'hF, 8'h00);
    check_eq("ien_gate", RR, 4'h0);
    run(OP_IEN, 4'h1, 8'h00);

    // Store and output enable
    run(OP_OEN, 4'h1, 8'h00);
    run(OP_LD, 4'h5, 8'h00);
    set_in(1'b1, OP_STOC, 4'h0, 8'h00);
    check_eq("stoc_write", WRITE, 1);
    check_eq("stoc_dout", DATA_OUT, 4'hA);
    tick();
    run(OP_OEN, 4'h0, 8'h00);
    set_in(1'b1, OP_STO, 4'h0, 8'h00);
    check_eq("sto_oen0_write", WRITE, 0);
    check_eq("sto_oen0_dout", DATA_OUT, 4'h0);
    tick();
    run(OP_OEN, 4'h1, 8'h00);
    for (int k = 0; k < 3; k++) run(OP_NOPF, 4'h0, 8'h00);
    check_eq("pc_0x10", PC, 8'h10);

    // Jump / return / skip after return
    set_in(1'b1, OP_JMP, 4'h0, 8'h40);
    check_eq("jmp_pulse", JMP, 1);
    tick();
    check_eq("jmp_pc", PC, 8'h40);
    set_in(1'b1, OP_RTN, 4'h0, 8'h00);
    check_eq("rtn_pulse", RTN, 1);
    tick();
    check_eq("rtn_pc", PC, 8'h11);
    set_in(1'b1, OP_LD, 4'h3, 8'h00);
    check_eq("skipped_no_pulse", WRITE | JMP | RTN | FLAG_O | FLAG_F, 0);
    tick();
    check_eq("skipped_ld_rr", RR, 4'h5);
    check_eq("skipped_ld_pc", PC, 8'h12);
    run(OP_LD, 4'h3, 8'h00);
    check_eq("ld_after_skip", RR, 4'h3);

    // SKZ held across EN=0
    run(OP_LD, 4'h0, 8'h00);
    check_eq("pc_before_skz", PC, 8'h14);
    run(OP_SKZ, 4'h0, 8'h00);
    set_in(1'b0, OP_NOPO, 4'h0, 8'h00);
    check_eq("en0_flag_o", FLAG_O, 0);
    tick(); tick();
    check_eq("en0_pc_hold", PC, 8'h15);
    run(OP_LD, 4'hC, 8'h00);
    check_eq("skz_ld_rr", RR, 4'h0);
    check_eq("skz_pc_plus2", PC, 8'h16);
    run(OP_LD, 4'hC, 8'h00);
    run(OP_SKZ, 4'h0, 8'h00);
    run(OP_LD, 4'h1, 8'h00);
    check_eq("skz_nonzero_noskip", RR, 4'h1);
    check_eq("pc_0x19", PC, 8'h19);

    // Stack overflow on the fifth nested jump
    run(OP_JMP, 4'h0, 8'h20);
    run(OP_JMP, 4'h0, 8'h30);
    run(OP_JMP, 4'h0, 8'h50);
    run(OP_JMP, 4'h0, 8'h60);
    check_eq("stk_full_no_err", STK_ERR, 0);
    run(OP_JMP, 4'h0, 8'h70);
    check_eq("stk_ovf_err", STK_ERR, 1);
    check_eq("stk_ovf_pc", PC, 8'h70);
    run(OP_RTN, 4'h0, 8'h00);
    check_eq("rtn_top_pc", PC, 8'h51);
    set_in(1'b1, OP_NOPO, 4'h0, 8'h00);
    check_eq("skipped_nopo_flag", FLAG_O, 0);
    tick();
    check_eq("pc_0x52", PC, 8'h52);

    // Reset mid-subroutine
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_eq("mid_rst_pc", PC, 0);
    check_eq("mid_rst_stk_err", STK_ERR, 0);
    run(OP_RTN, 4'h0, 8'h00);
    check_eq("rtn_empty_err", STK_ERR, 1);
    check_eq("rtn_empty_pc", PC, 8'h01);
    run(OP_LD, 4'hF, 8'h00);
    check_eq("rtn_empty_skip", RR, 4'h0);
    run(OP_LD, 4'h9, 8'h00);
    check_eq("rst_ien1", RR, 4'h9);
    set_in(1'b1, OP_STO, 4'h0, 8'h00);
    check_eq("rst_oen1_write", WRITE, 1);
    check_eq("rst_oen1_dout", DATA_OUT, 4'h9);
    tick();

    // PC wrap
    run(OP_JMP, 4'h0, 8'hFF);
    check_eq("pc_ff", PC, 8'hFF);
    set_in(1'b1, OP_NOPO, 4'h0, 8'h00);
    check_eq("nopo_flag_o", FLAG_O, 1);
    check_eq("nopo_flag_f", FLAG_F, 0);
    tick();
    check_eq("pc_wrap", PC, 8'h00);
    check_eq("stk_err_sticky", STK_ERR, 1);

    // Reset abandons a pending skip
    run(OP_LD, 4'h0, 8'h00);
    run(OP_SKZ, 4'h0, 8'h00);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    run(OP_LD, 4'h7, 8'h00);
    check_eq("rst_clears_skip", RR, 4'h7);
    check_eq("rst_clears_skip_pc", PC, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
